rvvi_tx_scheduler: RTL and testbench
====================================

// Module: rvvi_tx_scheduler
// PURPOSE
//  Arbitrates the single RVVI Ethernet transmit path between new trace packets from the tracer and
//  replay packets read from the RVVI active list. Writes every new packet into the active list as it
//  is sent, stalls the core when the list is full, and pulses a replay request when the oldest
//  outstanding packet has not been acknowledged within a timeout. Enforces an inter-frame gap.
// PARAMETERS
//  WIDTH          792   packet width in bits (matches active list entry width)
//  GAP_CYCLES     4     idle cycles after each accepted frame (0 = no gap)
//  MAX_BURST      4     consecutive replay grants before a pending new packet is forced through
//  TIMEOUT_CYCLES 1024  cycles without an ack, list non-empty, before ReplayReq pulses (>=2)
// PORTS
//  clk          in   1      clock
//  reset_n      in   1      asynchronous active-low reset
//  NewValid     in   1      tracer has a packet
//  NewData      in   WIDTH  tracer packet
//  NewReady     out  1      packet accepted this cycle when NewValid & NewReady
//  CoreStall    out  1      = ALFull; holds the core retire stage
//  ALWen        out  1      active list port-1 write enable
//  ALWData      out  WIDTH  active list port-1 write data (= NewData)
//  ALFull       in   1      active list full
//  ALEmpty      in   1      active list empty
//  ReplayBusy   in   1      active list is in its replay state
//  ReplayValid  in   1      active list port-3 data valid
//  ReplayData   in   WIDTH  active list port-3 data
//  ReplayStall  out  1      active list port-3 stall
//  AckValid     in   1      ack arriving on active list port 2 (observed only)
//  ReplayReq    out  1      one-cycle timeout pulse to active list replay trigger
//  TxValid      out  1      frame valid to MAC
//  TxData       out  WIDTH  frame data, stable while TxValid & ~TxReady
//  TxReady      in   1      MAC accepts frame
//  StatNew/StatReplay/StatTimeout out 32 each  statistics counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE; TxValid, NewReady, ALWen, ReplayReq=0; ReplayStall=1;
//   TxData, burst/gap/timeout counters, stats = 0. Outputs drop immediately, not at next edge.
//  States: IDLE, SEND (TxValid=1, TxData from internal buffer), GAP.
//  IDLE arbitration (combinational, decided same cycle):
//   PickReplay = ReplayBusy & ~(BurstCnt==MAX_BURST & NewValid & ~ALFull).
//   PickNew    = ~PickReplay & NewValid & ~ALFull.
//   ReplayStall = ~(IDLE & PickReplay); must not depend on ReplayValid (no comb loop).
//   NewReady = ALWen = IDLE & PickNew; ALWData = NewData.
//  Capture: IDLE & PickNew & NewValid -> buffer<=NewData, BurstCnt<=0, ->SEND.
//   IDLE & PickReplay & ReplayValid -> buffer<=ReplayData, BurstCnt<=min(BurstCnt+1,MAX_BURST), ->SEND.
//   PickReplay & ~ReplayValid -> remain IDLE, no capture.
//  Latency: accept at edge N, TxValid high from N (cycle after accept) until TxReady handshake.
//  SEND: TxValid & TxReady -> GAP (GapCnt<=GAP_CYCLES-1) or IDLE if GAP_CYCLES==0.
//  GAP: count down; at 0 -> IDLE. ReplayStall=1, NewReady=0 in SEND and GAP.
//  ALFull: NewReady=0, CoreStall=1; replay still served. BurstCnt saturates, never wraps.
//  Timeout counter: cleared when ALEmpty or AckValid; else increments. At TIMEOUT_CYCLES-1 ->
//   ReplayReq=1 one cycle, counter cleared. AckValid on the terminal cycle wins: no pulse.
//   Suppressed (counter held) while ReplayBusy.
// CONFIGURATION
//  RVVI_TX_STATS_EN defined: StatNew/StatReplay/StatTimeout count new frames, replay frames (on
//   TxReady handshake, tagged at capture) and ReplayReq pulses; saturate at 2^32-1; reset to 0.
//  Undefined: no counter flops; all three ports tied to 0. Ports exist in both builds.
// STRUCTURE
//  rvvi_pkg: typedef enum {TX_IDLE, TX_SEND, TX_GAP} rvvi_tx_state_t; default localparams for
//   WIDTH, GAP_CYCLES, TIMEOUT_CYCLES shared with the active list and MAC wrapper.
//  Sub-module rvvi_timeout_timer (clear, enable, terminal pulse) instanced once.
// TESTING
//  1 NewValid=1, ALFull=0, TxReady=1, GAP_CYCLES=4 -> ALWen 1 cycle, TxValid next cycle, 4 GAP cycles, NewReady again.
//  2 ReplayBusy=1, ReplayValid=1, NewValid=1 continuously, MAX_BURST=4 -> 4 replay frames then 1 new, repeating.
//  3 ALFull=1, NewValid=1 -> CoreStall=1, NewReady=0, ALWen never asserted; replay frames still sent.
//  4 TxReady=0 for 10 cycles in SEND -> TxValid and TxData unchanged; handshake on cycle 11.
//  5 ALEmpty=0, no AckValid, TIMEOUT_CYCLES=16 -> ReplayReq pulse every 16 cycles; AckValid at 15th -> no pulse.
//  6 reset_n low mid-SEND -> TxValid=0 asynchronously, ReplayStall=1; STATS build counters read 0.

Source files
------------

// File: rtl/rvvi_pkg.sv
// Shared RVVI transmit-path definitions.
//   - Default widths/timing shared by the active list, MAC wrapper and tx scheduler.
//   - rvvi_tx_state_t: transmit scheduler FSM states.
//   - cnt_width(): bits needed to hold a counter value 0..maxval (minimum 1).
package rvvi_pkg;

  localparam int unsigned RVVI_WIDTH          = 792;
  localparam int unsigned RVVI_GAP_CYCLES     = 4;
  localparam int unsigned RVVI_MAX_BURST      = 4;
  localparam int unsigned RVVI_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_GAP  = 2'd2
  } rvvi_tx_state_t;

  function automatic int unsigned cnt_width(input int unsigned maxval);
    return (maxval < 2) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/rvvi_timeout_timer.sv
// Ack timeout timer for the RVVI active list.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : zero the counter (list empty or ack seen); wins over everything
//   enable       : count this cycle; when low the counter holds
//   terminal     : one-cycle pulse when the counter sits at TIMEOUT_CYCLES-1 and is enabled;
//                  the counter restarts from 0 on the following cycle
module rvvi_timeout_timer
  import rvvi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = RVVI_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int unsigned CntW = cnt_width(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    terminal = enable & ~clear & (cnt_q == CntLast);
    cnt_d    = cnt_q;
    if (clear || terminal) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rvvi_tx_scheduler.sv
// RVVI Ethernet transmit scheduler.
// Arbitrates the single MAC transmit path between new tracer packets and replay packets from
// the active list, writes each accepted new packet into the active list, stalls the core while
// the list is full, pulses ReplayReq on an ack timeout and inserts an inter-frame gap.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   NewValid/NewData/NewReady         tracer packet handshake
//   CoreStall                         holds core retire (= ALFull)
//   ALWen/ALWData                     active list write port (new packets)
//   ALFull/ALEmpty/ReplayBusy         active list status
//   ReplayValid/ReplayData/ReplayStall active list replay read port
//   AckValid                          ack seen by the active list (observed only)
//   ReplayReq                         one-cycle timeout pulse
//   TxValid/TxData/TxReady            frame handshake to the MAC
//   StatNew/StatReplay/StatTimeout    statistics counters
// Build option: define RVVI_TX_STATS_EN to implement the statistics counters; otherwise the
// Stat* ports are tied to zero.
module rvvi_tx_scheduler
  import rvvi_pkg::*;
#(
  parameter int unsigned WIDTH          = RVVI_WIDTH,
  parameter int unsigned GAP_CYCLES     = RVVI_GAP_CYCLES,
  parameter int unsigned MAX_BURST      = RVVI_MAX_BURST,
  parameter int unsigned TIMEOUT_CYCLES = RVVI_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             NewValid,
  input  logic [WIDTH-1:0] NewData,
  output logic             NewReady,
  output logic             CoreStall,
  output logic             ALWen,
  output logic [WIDTH-1:0] ALWData,
  input  logic             ALFull,
  input  logic             ALEmpty,
  input  logic             ReplayBusy,
  input  logic             ReplayValid,
  input  logic [WIDTH-1:0] ReplayData,
  output logic             ReplayStall,
  input  logic             AckValid,
  output logic             ReplayReq,
  output logic             TxValid,
  output logic [WIDTH-1:0] TxData,
  input  logic             TxReady,
  output logic [31:0]      StatNew,
  output logic [31:0]      StatReplay,
  output logic [31:0]      StatTimeout
);

  localparam int unsigned BurstW = cnt_width(MAX_BURST);
  localparam int unsigned GapW   = cnt_width(GAP_CYCLES);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_BURST);
  localparam logic [GapW-1:0]   GapLoad  = GapW'(GAP_CYCLES - 1);

  rvvi_tx_state_t   state_q, state_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic [BurstW-1:0] burst_q, burst_d;
  logic [GapW-1:0]  gap_q, gap_d;

  logic idle;
  logic pick_replay;
  logic pick_new;

  // Replay wins unless the burst budget is spent and a new packet could actually be taken.
  assign idle        = (state_q == TX_IDLE);
  assign pick_replay = ReplayBusy & ~((burst_q == BurstMax) & NewValid & ~ALFull);
  assign pick_new    = ~pick_replay & NewValid & ~ALFull;

  // Gated with reset_n so the handshakes drop the moment reset asserts.
  assign NewReady    = reset_n & idle & pick_new;
  assign ALWen       = NewReady;
  assign ALWData     = NewData;
  assign ReplayStall = ~(reset_n & idle & pick_replay);
  assign CoreStall   = ALFull;
  assign TxValid     = (state_q == TX_SEND);
  assign TxData      = buf_q;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    burst_d = burst_q;
    gap_d   = gap_q;
    unique case (state_q)
      TX_IDLE: begin
        if (pick_new) begin
          buf_d   = NewData;
          burst_d = '0;
          state_d = TX_SEND;
        end else if (pick_replay && ReplayValid) begin
          buf_d   = ReplayData;
          burst_d = (burst_q == BurstMax) ? burst_q : burst_q + BurstW'(1);
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (TxReady) begin
          if (GAP_CYCLES == 0) begin
            state_d = TX_IDLE;
          end else begin
            gap_d   = GapLoad;
            state_d = TX_GAP;
          end
        end
      end
      TX_GAP: begin
        if (gap_q == '0) begin
          state_d = TX_IDLE;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= TX_IDLE;
      buf_q   <= '0;
      burst_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      burst_q <= burst_d;
      gap_q   <= gap_d;
    end
  end

  // Counter is held while the active list is already replaying.
  rvvi_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (ALEmpty | AckValid),
    .enable  (~ReplayBusy),
    .terminal(ReplayReq)
  );

`ifdef RVVI_TX_STATS_EN
  logic        tag_replay_q;
  logic [31:0] stat_new_q, stat_rep_q, stat_to_q;
  logic        tx_done;

  assign tx_done = TxValid & TxReady;

  // Frame kind is tagged at capture and counted when the MAC takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_replay_q <= 1'b0;
      stat_new_q   <= '0;
      stat_rep_q   <= '0;
      stat_to_q    <= '0;
    end else begin
      if (idle) begin
        if (pick_new) begin
          tag_replay_q <= 1'b0;
        end else if (pick_replay && ReplayValid) begin
          tag_replay_q <= 1'b1;
        end
      end
      if (tx_done && !tag_replay_q && (stat_new_q != '1)) begin
        stat_new_q <= stat_new_q + 32'd1;
      end
      if (tx_done && tag_replay_q && (stat_rep_q != '1)) begin
        stat_rep_q <= stat_rep_q + 32'd1;
      end
      if (ReplayReq && (stat_to_q != '1)) begin
        stat_to_q <= stat_to_q + 32'd1;
      end
    end
  end

  assign StatNew     = stat_new_q;
  assign StatReplay  = stat_rep_q;
  assign StatTimeout = stat_to_q;
`else
  assign StatNew     = '0;
  assign StatReplay  = '0;
  assign StatTimeout = '0;
`endif

endmodule

// File: tb/tb_rvvi_tx_scheduler.sv
module tb_rvvi_tx_scheduler;

  localparam int unsigned W   = 32;
  localparam int unsigned GAP = 4;
  localparam int unsigned MB  = 4;
  localparam int unsigned TO  = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         NewValid, NewReady, CoreStall, ALWen;
  logic [W-1:0] NewData, ALWData, ReplayData, TxData;
  logic         ALFull, ALEmpty, ReplayBusy, ReplayValid, ReplayStall;
  logic         AckValid, ReplayReq, TxValid, TxReady;
  logic [31:0]  StatNew, StatReplay, StatTimeout;

  rvvi_tx_scheduler #(
    .WIDTH         (W),
    .GAP_CYCLES    (GAP),
    .MAX_BURST     (MB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .NewValid   (NewValid),
    .NewData    (NewData),
    .NewReady   (NewReady),
    .CoreStall  (CoreStall),
    .ALWen      (ALWen),
    .ALWData    (ALWData),
    .ALFull     (ALFull),
    .ALEmpty    (ALEmpty),
    .ReplayBusy (ReplayBusy),
    .ReplayValid(ReplayValid),
    .ReplayData (ReplayData),
    .ReplayStall(ReplayStall),
    .AckValid   (AckValid),
    .ReplayReq  (ReplayReq),
    .TxValid    (TxValid),
    .TxData     (TxData),
    .TxReady    (TxReady),
    .StatNew    (StatNew),
    .StatReplay (StatReplay),
    .StatTimeout(StatTimeout)
  );

  always #5 clk = ~clk;

  // One clock cycle of stimulus and the outputs expected in that cycle.
  typedef struct {
    bit nv, af, rb, rv, tr;
    bit e_nr, e_tv, e_rs;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] sb_data[$];
  bit           sb_rep[$];
  int           checks = 0;
  int           errors = 0;
  logic [31:0]  n_new = '0;
  logic [31:0]  n_rep = '0;
  logic [W-1:0] new_data = 32'hA000_0000;
  logic [W-1:0] rep_data = 32'h5000_0000;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_row(input bit nv, af, rb, rv, tr, e_nr, e_tv, e_rs);
    vec_t v;
    v = '{nv, af, rb, rv, tr, e_nr, e_tv, e_rs};
    vecs.push_back(v);
  endtask

  // IDLE pick cycle, optional MAC back-pressure, handshake, then the gap.
  task automatic add_frame(input bit nv, af, rb, rv, rep, input int stall);
    add_row(nv, af, rb, rv, 1'b1, !rep, 1'b0, !rep);
    for (int i = 0; i < stall; i++) add_row(nv, af, rb, rv, 1'b0, 1'b0, 1'b1, 1'b1);
    add_row(nv, af, rb, rv, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < int'(GAP); i++) add_row(nv, af, rb, rv, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    // Plain new frames, then one held by the MAC for 10 cycles.
    add_frame(1, 0, 0, 0, 0, 0);
    add_frame(1, 0, 0, 0, 0, 0);
    add_frame(1, 0, 0, 0, 0, 10);
    // Replay burst of MB frames then a forced new frame, twice.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < int'(MB); i++) add_frame(1, 0, 1, 1, 1, 0);
      add_frame(1, 0, 1, 1, 0, 0);
    end
    // List full: replays keep flowing past MB, burst count saturates.
    for (int i = 0; i < int'(MB) + 1; i++) add_frame(1, 1, 1, 1, 1, 0);
    add_row(1, 1, 0, 0, 1, 0, 0, 1);
    add_row(1, 1, 0, 0, 1, 0, 0, 1);
    // Replay picked but no data yet: port opened, nothing captured.
    add_row(1, 1, 1, 0, 1, 0, 0, 0);
    add_row(1, 1, 1, 0, 1, 0, 0, 0);
    // List drains with saturated burst: the new packet goes first.
    add_frame(1, 0, 1, 1, 0, 0);

    reset_n = 1'b0;
    NewValid = 0; NewData = '0; ALFull = 0; ALEmpty = 1; ReplayBusy = 0;
    ReplayValid = 0; ReplayData = '0; AckValid = 0; TxReady = 0;
    #12;
    chk1("rst_txvalid", TxValid, 1'b0);
    chk1("rst_newready", NewReady, 1'b0);
    chk1("rst_alwen", ALWen, 1'b0);
    chk1("rst_replayreq", ReplayReq, 1'b0);
    chk1("rst_replaystall", ReplayStall, 1'b1);
    chkw("rst_txdata", TxData, '0);
    @(posedge clk); #1 reset_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      NewValid = vecs[i].nv; ALFull = vecs[i].af; ReplayBusy = vecs[i].rb;
      ReplayValid = vecs[i].rv; TxReady = vecs[i].tr;
      NewData = new_data; ReplayData = rep_data;
      @(negedge clk);
      chk1("newready", NewReady, vecs[i].e_nr);
      chk1("alwen", ALWen, vecs[i].e_nr);
      chk1("txvalid", TxValid, vecs[i].e_tv);
      chk1("replaystall", ReplayStall, vecs[i].e_rs);
      chk1("corestall", CoreStall, vecs[i].af);
      chk1("replayreq_idle", ReplayReq, 1'b0);
      if (vecs[i].e_nr) chkw("alwdata", ALWData, new_data);
      if (TxValid) begin
        if (sb_data.size() == 0) begin
          checks++; errors++;
          $display("FAIL txdata: frame %h sent with empty scoreboard", TxData);
        end else begin
          chkw("txdata", TxData, sb_data[0]);
          if (TxReady) begin
            void'(sb_data.pop_front());
            if (sb_rep.pop_front()) n_rep++; else n_new++;
          end
        end
      end
      if (vecs[i].e_nr && vecs[i].nv) begin
        sb_data.push_back(new_data); sb_rep.push_back(1'b0); new_data += 32'h11;
      end
      if (!vecs[i].e_rs && vecs[i].rv) begin
        sb_data.push_back(rep_data); sb_rep.push_back(1'b1); rep_data += 32'h101;
      end
    end
    chkw("sb_empty", 32'(sb_data.size()), 32'd0);
    chkw("new_frames", n_new, 32'd6);
    chkw("replay_frames", n_rep, 32'd13);
`ifdef RVVI_TX_STATS_EN
    chkw("stat_new", StatNew, n_new);
    chkw("stat_replay", StatReplay, n_rep);
`else
    chkw("stat_new_tied", StatNew, '0);
    chkw("stat_replay_tied", StatReplay, '0);
`endif

    // Timeout: pulses every TO cycles; ack on the terminal cycle suppresses one;
    // ReplayBusy holds the counter.
    for (int k = 0; k <= 99; k++) begin
      @(posedge clk); #1;
      NewValid = 0; ALFull = 0; ReplayValid = 0; TxReady = 1; ALEmpty = 0;
      AckValid = (k == 47);
      ReplayBusy = (k >= 66 && k < 86);
      @(negedge clk);
      chk1($sformatf("replayreq_k%0d", k), ReplayReq, (k == 15 || k == 31 || k == 63 || k == 99));
    end
`ifdef RVVI_TX_STATS_EN
    chkw("stat_timeout", StatTimeout, 32'd4);
`else
    chkw("stat_timeout_tied", StatTimeout, '0);
`endif

    // Reset in the middle of a frame.
    @(posedge clk); #1;
    ALEmpty = 1; ReplayBusy = 0; AckValid = 0; TxReady = 0; NewValid = 1; NewData = 32'hDEAD_BEEF;
    @(posedge clk); #2;
    chk1("send_before_reset", TxValid, 1'b1);
    chkw("send_data_before_reset", TxData, 32'hDEAD_BEEF);
    reset_n = 1'b0;
    #1;
    chk1("async_txvalid", TxValid, 1'b0);
    chk1("async_replaystall", ReplayStall, 1'b1);
    chk1("async_newready", NewReady, 1'b0);
    chkw("async_txdata", TxData, '0);
    chkw("async_statnew", StatNew, '0);
    chkw("async_statreplay", StatReplay, '0);
    chkw("async_stattimeout", StatTimeout, '0);
    #20 reset_n = 1'b1;
    #10;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
